// File: rtl/envelope_follower.sv
// Envelope follower: rectify -> attack/release smoothing -> hysteresis/hold gate.
// Optional peak tracker enabled by defining ENV_FOLLOWER_PEAK_EN.
module envelope_follower #(
    parameter int SAMPLE_BITS  = 12,
    parameter int HOLD_SAMPLES = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_valid,
    input  logic signed [SAMPLE_BITS-1:0] sample,
    input  logic [3:0]                    a,
    input  logic [3:0]                    r,
    input  logic [3:0]                    threshold,
`ifdef ENV_FOLLOWER_PEAK_EN
    input  logic                          peak_clr,
    output logic [7:0]                    peak,
`endif
    output logic [7:0]                    envelope,
    output logic                          env_valid,
    output logic                          gate
);

    localparam int CW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
    localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_SAMPLES - 1);
    localparam logic [SAMPLE_BITS-1:0] MAG_MAX = {1'b0, {(SAMPLE_BITS-1){1'b1}}};

    typedef enum logic [1:0] {ST_CLOSED, ST_OPEN, ST_HOLD} gate_st_t;

    // [0] = stage-1 result valid, [1] = envelope valid (gate evaluates next edge)
    logic [1:0]             r_vld_pipe;
    logic [7:0]             r_target;
    logic [15:0]            r_env_acc;
    logic [7:0]             r_open_th;
    gate_st_t               r_state;
    logic [CW-1:0]          r_hold_cnt;

    logic [SAMPLE_BITS-1:0] w_mag;
    logic [15:0]            w_tgt16;
    logic [15:0]            w_diff;
    logic [15:0]            w_step;
    logic [15:0]            w_acc_nxt;
    logic [7:0]             w_close_th;
    gate_st_t               w_state_nxt;
    logic [CW-1:0]          w_hold_nxt;

    always_comb begin
        w_mag = $unsigned(sample);
        if (sample[SAMPLE_BITS-1]) begin
            if (sample[SAMPLE_BITS-2:0] == '0) w_mag = MAG_MAX;
            else                               w_mag = $unsigned(-sample);
        end
    end

    // Step is clamped to at least 1 so the accumulator always converges,
    // and never exceeds the distance so it cannot overshoot or wrap.
    always_comb begin
        w_tgt16   = {r_target, 8'h00};
        w_diff    = '0;
        w_step    = '0;
        w_acc_nxt = r_env_acc;
        if (w_tgt16 > r_env_acc) begin
            w_diff = w_tgt16 - r_env_acc;
            w_step = w_diff >> a;
            if (w_step == '0) w_step = 16'd1;
            w_acc_nxt = r_env_acc + w_step;
        end else if (w_tgt16 < r_env_acc) begin
            w_diff = r_env_acc - w_tgt16;
            w_step = w_diff >> r;
            if (w_step == '0) w_step = 16'd1;
            w_acc_nxt = r_env_acc - w_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_target   <= '0;
            r_env_acc  <= '0;
            r_open_th  <= '0;
            envelope   <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], sample_valid};
            if (sample_valid) r_target <= w_mag[SAMPLE_BITS-2 -: 8];
            if (r_vld_pipe[0]) begin
                r_env_acc <= w_acc_nxt;
                envelope  <= w_acc_nxt[15:8];
                r_open_th <= {threshold, 4'b0000};
            end
        end
    end

    assign env_valid  = r_vld_pipe[1];
    assign w_close_th = (r_open_th >= 8'd8) ? (r_open_th - 8'd8) : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLOSED;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        if (env_valid) begin
            case (r_state)
                ST_CLOSED: if (envelope >= r_open_th) w_state_nxt = ST_OPEN;
                ST_OPEN: begin
                    if (envelope < w_close_th) begin
                        w_state_nxt = ST_HOLD;
                        w_hold_nxt  = HOLD_INIT;
                    end
                end
                ST_HOLD: begin
                    if (envelope >= r_open_th)  w_state_nxt = ST_OPEN;
                    else if (r_hold_cnt == '0)  w_state_nxt = ST_CLOSED;
                    else                        w_hold_nxt  = r_hold_cnt - CW'(1);
                end
                default: w_state_nxt = ST_CLOSED;
            endcase
        end
    end

    assign gate = (r_state != ST_CLOSED);

`ifdef ENV_FOLLOWER_PEAK_EN
    // A clear coinciding with a fresh envelope restarts the peak from that envelope.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak <= '0;
        end else if (r_vld_pipe[0]) begin
            if (peak_clr || (w_acc_nxt[15:8] > peak)) peak <= w_acc_nxt[15:8];
        end else if (peak_clr) begin
            peak <= '0;
        end
    end
`endif

endmodule
